// File: rtl/harmonic_mixer.sv
// Harmonic mixer: requests one sample from each of three harmonic generators, sums them and hands the result to the codec.
// Output formatting is selected by HARMONIC_MIXER_SATURATE_EN (clamp to 16 bits) or its absence (arithmetic divide by 4).
module harmonic_mixer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        generate_next_sample,
  input  logic [15:0] h0_sample,
  input  logic [15:0] h1_sample,
  input  logic [15:0] h2_sample,
  input  logic        h0_ready,
  input  logic        h1_ready,
  input  logic        h2_ready,
  output logic        harmonic_request,
  output logic [15:0] mixed_sample,
  output logic        mixed_ready,
  output logic        timeout_flag,
  output logic        overrun_flag
);

  localparam int unsigned SW   = 16;
  localparam int unsigned SUMW = 18;
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SUM,
    ST_DONE
  } state_t;

  state_t            state;
  logic [2:0]        got;
  logic [CNTW-1:0]   wait_cnt;
  logic [SW-1:0]     h0_q;
  logic [SW-1:0]     h1_q;
  logic [SW-1:0]     h2_q;
  logic [SW-1:0]     result;

  logic              capture_c;
  logic [2:0]        rdy_c;
  logic [2:0]        got_c;
  logic              timeout_c;
  logic signed [SUMW-1:0] sum_c;
  logic [SW-1:0]     fmt_c;

  // Only the first ready per harmonic is taken, and only while a request is outstanding.
  assign capture_c = (state == ST_REQ) || (state == ST_WAIT);
  assign rdy_c     = {h2_ready, h1_ready, h0_ready} & ~got & {3{capture_c}};
  assign got_c     = got | rdy_c;
  assign timeout_c = (state == ST_WAIT) && (got_c != 3'b111) &&
                     (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    sum_c = SUMW'($signed(h0_q)) + SUMW'($signed(h1_q)) + SUMW'($signed(h2_q));
    fmt_c = '0;
`ifdef HARMONIC_MIXER_SATURATE_EN
    if (sum_c > 18'sd32767) begin
      fmt_c = 16'h7fff;
    end else if (sum_c < -18'sd32768) begin
      fmt_c = 16'h8000;
    end else begin
      fmt_c = SW'(sum_c);
    end
`else
    fmt_c = SW'(sum_c >>> 2);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      got              <= '0;
      wait_cnt         <= '0;
      h0_q             <= '0;
      h1_q             <= '0;
      h2_q             <= '0;
      result           <= '0;
      harmonic_request <= 1'b0;
      mixed_sample     <= '0;
      mixed_ready      <= 1'b0;
      timeout_flag     <= 1'b0;
      overrun_flag     <= 1'b0;
    end else begin
      harmonic_request <= 1'b0;
      mixed_ready      <= 1'b0;
      got              <= got_c;

      if (generate_next_sample && (state != ST_IDLE)) begin
        overrun_flag <= 1'b1;
      end
      if (rdy_c[0]) h0_q <= h0_sample;
      if (rdy_c[1]) h1_q <= h1_sample;
      if (rdy_c[2]) h2_q <= h2_sample;

      case (state)
        ST_IDLE: begin
          if (generate_next_sample && play_enable) begin
            state            <= ST_REQ;
            harmonic_request <= 1'b1;
            wait_cnt         <= '0;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNTW'(1);
          if (got_c == 3'b111) begin
            state <= ST_SUM;
          end else if (timeout_c) begin
            // Harmonics that never answered contribute silence.
            if (!got_c[0]) h0_q <= '0;
            if (!got_c[1]) h1_q <= '0;
            if (!got_c[2]) h2_q <= '0;
            timeout_flag <= 1'b1;
            state        <= ST_SUM;
          end
        end
        ST_SUM: begin
          result <= fmt_c;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          mixed_sample <= result;
          mixed_ready  <= 1'b1;
          got          <= '0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Randomized self-checking bench for harmonic_mixer against an arithmetic reference model.
module tb_harmonic_mixer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_enable;
  logic        generate_next_sample;
  logic [15:0] h0_sample, h1_sample, h2_sample;
  logic        h0_ready, h1_ready, h2_ready;
  logic        harmonic_request;
  logic signed [15:0] mixed_sample;
  logic        mixed_ready;
  logic        timeout_flag;
  logic        overrun_flag;

  int vectors = 0;
  int miscompares = 0;
  int req_cnt = 0;
  int rdy_cnt = 0;

  harmonic_mixer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .generate_next_sample (generate_next_sample),
    .h0_sample            (h0_sample),
    .h1_sample            (h1_sample),
    .h2_sample            (h2_sample),
    .h0_ready             (h0_ready),
    .h1_ready             (h1_ready),
    .h2_ready             (h2_ready),
    .harmonic_request     (harmonic_request),
    .mixed_sample         (mixed_sample),
    .mixed_ready          (mixed_ready),
    .timeout_flag         (timeout_flag),
    .overrun_flag         (overrun_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (harmonic_request === 1'b1) req_cnt++;
    if (mixed_ready === 1'b1) rdy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Mixed output as the codec should see it: plain integer sum, then clamp or floor-divide by 4.
  function automatic int model(input int a, input int b, input int c);
    int s;
    s = a + b + c;
`ifdef HARMONIC_MIXER_SATURATE_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    return s >>> 2;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_h(input int i, input logic r, input logic [15:0] s);
    case (i)
      0: begin h0_ready = r; h0_sample = s; end
      1: begin h1_ready = r; h1_sample = s; end
      2: begin h2_ready = r; h2_sample = s; end
      default: ;
    endcase
  endtask

  // d*: cycle (0 = request cycle) of each ready pulse, -1 = never; rep: harmonic re-pulsed a cycle later
  // with a different value; ovr_k / drop_k: cycle to pulse generate_next_sample / drop play_enable.
  task automatic do_txn(input string name, input int v0, input int v1, input int v2,
                        input int d0, input int d1, input int d2,
                        input int rep, input int ovr_k, input int drop_k);
    int d[3];
    int v[3];
    int e[3];
    bit to;
    int last, exp_v, exp_k, hit, rq0, rd0;
    d[0] = d0; d[1] = d1; d[2] = d2;
    v[0] = v0; v[1] = v1; v[2] = v2;
    to = 1'b0;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      if (d[i] < 0) begin
        to = 1'b1;
        e[i] = 0;
      end else begin
        e[i] = v[i];
        if (d[i] > last) last = d[i];
      end
    end
    exp_v = model(e[0], e[1], e[2]);
    exp_k = to ? TIMEOUT + 2 : last + 2;
    rq0 = req_cnt;
    rd0 = rdy_cnt;
    hit = -1;

    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    vectors++;
    if (harmonic_request !== 1'b1) begin
      miscompares++;
      $display("FAIL %s request_pulse: got %b want 1", name, harmonic_request);
    end

    for (int k = 0; k < TIMEOUT + 20; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (d[i] == k) set_h(i, 1'b1, 16'(v[i]));
        else if (rep == i && d[i] >= 0 && d[i] + 1 == k) set_h(i, 1'b1, 16'(v[i] + 777));
        else set_h(i, 1'b0, 16'($urandom));
      end
      generate_next_sample = (k == ovr_k);
      if (k == drop_k) play_enable = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) set_h(i, 1'b0, 16'($urandom));
      generate_next_sample = 1'b0;
      if (mixed_ready === 1'b1) begin
        hit = k;
        break;
      end
    end

    vectors++;
    if (hit != exp_k) begin
      miscompares++;
      $display("FAIL %s latency: got cycle %0d want %0d", name, hit, exp_k);
    end
    vectors++;
    if (int'(mixed_sample) != exp_v) begin
      miscompares++;
      $display("FAIL %s mixed_sample: got %0d want %0d", name, int'(mixed_sample), exp_v);
    end
    if (to) begin
      vectors++;
      if (timeout_flag !== 1'b1) begin
        miscompares++;
        $display("FAIL %s timeout_flag: got %b want 1", name, timeout_flag);
      end
    end
    if (ovr_k >= 0) begin
      vectors++;
      if (overrun_flag !== 1'b1) begin
        miscompares++;
        $display("FAIL %s overrun_flag: got %b want 1", name, overrun_flag);
      end
    end
    tick();
    vectors++;
    if (mixed_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ready_width: got %b want 0 one cycle later", name, mixed_ready);
    end
    vectors++;
    if ((req_cnt - rq0) != 1 || (rdy_cnt - rd0) != 1) begin
      miscompares++;
      $display("FAIL %s pulse_count: got req=%0d ready=%0d want 1/1", name, req_cnt - rq0, rdy_cnt - rd0);
    end
    play_enable = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if (mixed_sample !== 16'sd0 || mixed_ready !== 1'b0 || harmonic_request !== 1'b0 ||
        timeout_flag !== 1'b0 || overrun_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL %s outputs: got sample=%0d ready=%b req=%b to=%b ovr=%b want all 0",
               name, mixed_sample, mixed_ready, harmonic_request, timeout_flag, overrun_flag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    play_enable = 1'b1;
    generate_next_sample = 1'b0;
    for (int i = 0; i < 3; i++) set_h(i, 1'b0, 16'($urandom));
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_ready_order();
    do_txn("order_h2_h0_h1", 1000, 2000, 3000, 2, 3, 1, -1, -1, -1);
  endtask

  task automatic test_random();
    logic signed [15:0] r0, r1, r2;
    for (int n = 0; n < 20; n++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      r2 = 16'($urandom);
      do_txn("random", int'(r0), int'(r1), int'(r2),
             int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
             -1, -1, -1);
    end
  endtask

  task automatic test_simultaneous();
    do_txn("simul_pos", 20000, 20000, 20000, 2, 2, 2, -1, -1, -1);
    do_txn("simul_neg", -20000, -20000, -20000, 2, 2, 2, -1, -1, -1);
  endtask

  task automatic test_repeat();
    do_txn("repeat_h0", 111, 222, 333, 1, 4, 3, 0, -1, -1);
  endtask

  task automatic test_play_drop();
    do_txn("play_drop", -500, 700, 1200, 3, 1, 2, -1, -1, 1);
  endtask

  task automatic test_overrun();
    do_txn("overrun", 10, 20, 30, 2, 4, 3, -1, 2, -1);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 100, 4242, 100, 3, -1, 5, -1, -1, -1);
  endtask

  task automatic test_reset_mid();
    int rd0;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    set_h(0, 1'b1, 16'd12345);
    tick();
    set_h(0, 1'b0, 16'($urandom));
    rd0 = rdy_cnt;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    tick();
    tick();
    reset = 1'b1;
    repeat (5) tick();
    vectors++;
    if (rdy_cnt != rd0) begin
      miscompares++;
      $display("FAIL reset_mid stray_ready: got %0d pulses want 0", rdy_cnt - rd0);
    end
    do_txn("stale_h0", 12345, 300, 500, -1, 2, 3, -1, -1, -1);
  endtask

  task automatic test_play_disable();
    int rq0, rd0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    play_enable = 1'b0;
    rq0 = req_cnt;
    rd0 = rdy_cnt;
    repeat (10) begin
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
      tick();
    end
    repeat (5) tick();
    vectors++;
    if (req_cnt != rq0 || rdy_cnt != rd0) begin
      miscompares++;
      $display("FAIL play_disable pulses: got req=%0d ready=%0d want 0/0", req_cnt - rq0, rdy_cnt - rd0);
    end
    vectors++;
    if (mixed_sample !== 16'sd0 || overrun_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL play_disable state: got sample=%0d ovr=%b want 0/0", mixed_sample, overrun_flag);
    end
    play_enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ready_order();
    test_random();
    test_simultaneous();
    test_repeat();
    test_play_drop();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_play_disable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
